elev_dispatch: RTL and testbench

ELEV_DISPATCH -- requirements
Module: elev_dispatch

---
 rtl/elev_dispatch.sv | 271 +++++++++++++++++++++++++++
 tb/tb_elev_dispatch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/elev_dispatch.sv
// elev_dispatch -- call dispatcher for a three-floor elevator car.
//
// Latches call buttons into pending lamps, picks the next target floor
// using a collective (keep going in the current direction) policy,
// hands one-hot target requests to the car controller and clears the
// served call once the door has opened at the target.  After IDLE_TO
// idle cycles away from floor 1 the car is sent home to floor 1.
//
// Parameters
//   IDLE_TO            idle cycles (1..255) before homing to floor 1
// Ports
//   clk                single clock, rising edge
//   Reset              asynchronous reset, active low
//   Btn[3:1]           call buttons, bit n = floor n
//   FLR1, FLR2, FLR3   car position, one-hot when valid
//   Door               car door open
//   Req[3:1]           registered one-hot target request, 000 = none
//   Pend[3:1]          registered pending-call lamps
//   Dir                registered travel direction, 1 = up, 0 = down
//   Busy               high whenever the dispatcher is not idle
module elev_dispatch #(
  parameter int unsigned IDLE_TO = 16
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [3:1] Btn,
  input  logic       FLR1,
  input  logic       FLR2,
  input  logic       FLR3,
  input  logic       Door,
  output logic [3:1] Req,
  output logic [3:1] Pend,
  output logic       Dir,
  output logic       Busy
);

  localparam logic [7:0] IDLE_LIMIT = 8'(IDLE_TO);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ISSUE,
    WAIT,
    CLEAR,
    HOME
  } state_t;

  state_t     state, state_n;
  logic [1:0] pos, pos_n;
  logic [1:0] target, target_n;
  logic       dir_n;
  logic [7:0] timer, timer_n;
  logic [3:1] req_n;
  logic [3:1] clr;
  logic [3:1] pend_n;

  function automatic logic [3:1] onehot(input logic [1:0] f);
    case (f)
      2'd1:    onehot = 3'b001;
      2'd2:    onehot = 3'b010;
      2'd3:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // ---------------------------------------------------------------
  // Car position: only a clean one-hot reading is trusted; anything
  // else (between floors, sensor glitch) keeps the last known floor.
  // ---------------------------------------------------------------
  logic [3:1] flr;
  logic       flr_valid;
  logic [1:0] flr_pos;

  assign flr = {FLR3, FLR2, FLR1};

  always_comb begin
    flr_valid = 1'b1;
    flr_pos   = 2'd1;
    case (flr)
      3'b001:  flr_pos = 2'd1;
      3'b010:  flr_pos = 2'd2;
      3'b100:  flr_pos = 2'd3;
      default: flr_valid = 1'b0;
    endcase
  end

  assign pos_n = flr_valid ? flr_pos : pos;

  // ---------------------------------------------------------------
  // Pending calls: the clear term is applied after the OR so a press
  // of the floor being served in the same cycle is swallowed.
  // ---------------------------------------------------------------
  assign clr    = (state == CLEAR) ? onehot(target) : 3'b000;
  assign pend_n = (Pend | Btn) & ~clr;

  // ---------------------------------------------------------------
  // Target selection from the held position and current direction.
  // ---------------------------------------------------------------
  logic       up_hit, dn_hit;
  logic [1:0] up_flr, dn_flr;
  logic       sel_found, sel_flip;
  logic [1:0] sel_target;

  always_comb begin
    up_hit = 1'b0;
    up_flr = 2'd3;
    dn_hit = 1'b0;
    dn_flr = 2'd1;
    case (pos)
      2'd1: begin
        if (Pend[2]) begin
          up_hit = 1'b1;
          up_flr = 2'd2;
        end else if (Pend[3]) begin
          up_hit = 1'b1;
          up_flr = 2'd3;
        end
      end
      2'd2: begin
        if (Pend[3]) begin
          up_hit = 1'b1;
          up_flr = 2'd3;
        end
        if (Pend[1]) begin
          dn_hit = 1'b1;
          dn_flr = 2'd1;
        end
      end
      2'd3: begin
        if (Pend[2]) begin
          dn_hit = 1'b1;
          dn_flr = 2'd2;
        end else if (Pend[1]) begin
          dn_hit = 1'b1;
          dn_flr = 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    sel_found  = 1'b1;
    sel_flip   = 1'b0;
    sel_target = pos;
    if ((Pend & onehot(pos)) != 3'b000) begin
      sel_target = pos;
    end else if (Dir && up_hit) begin
      sel_target = up_flr;
    end else if (!Dir && dn_hit) begin
      sel_target = dn_flr;
    end else if (Dir && dn_hit) begin
      sel_target = dn_flr;
      sel_flip   = 1'b1;
    end else if (!Dir && up_hit) begin
      sel_target = up_flr;
      sel_flip   = 1'b1;
    end else begin
      sel_found  = 1'b0;
    end
  end

  // A fresh floor reading strictly between the current floor and the
  // target with a call waiting there, while the door is shut.
  logic pickup;

  always_comb begin
    pickup = 1'b0;
    if (flr_valid && !Door && (flr_pos != pos) &&
        ((Pend & onehot(flr_pos)) != 3'b000)) begin
      if ((pos < flr_pos) && (flr_pos < target)) pickup = 1'b1;
      if ((pos > flr_pos) && (flr_pos > target)) pickup = 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    state_n  = state;
    target_n = target;
    dir_n    = Dir;
    timer_n  = 8'd0;

    case (state)
      IDLE: begin
        if (Pend != 3'b000) begin
          state_n = SELECT;
        end else if (Btn != 3'b000) begin
          timer_n = 8'd0;
        end else if ((timer == IDLE_LIMIT) && (pos != 2'd1)) begin
          state_n = HOME;
          dir_n   = 1'b0;
        end else begin
          timer_n = (timer == 8'hFF) ? timer : timer + 8'd1;
        end
      end

      SELECT: begin
        if (sel_found) begin
          state_n  = ISSUE;
          target_n = sel_target;
          if (sel_flip) dir_n = ~Dir;
        end else begin
          state_n = IDLE;
        end
      end

      ISSUE: state_n = WAIT;

      WAIT: begin
        if (Door && (pos == target)) begin
          state_n = CLEAR;
        end else if (pickup) begin
          target_n = flr_pos;
        end
      end

      CLEAR: begin
        if (!Door) state_n = (pend_n != 3'b000) ? SELECT : IDLE;
      end

      HOME: begin
        if (Btn != 3'b000) begin
          state_n = SELECT;
        end else if (pos == 2'd1) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // Req is registered against the state being entered, so it always
  // reflects the state the dispatcher is in during that cycle.
  always_comb begin
    req_n = 3'b000;
    case (state_n)
      ISSUE, WAIT: req_n = onehot(target_n);
      HOME:        req_n = 3'b001;
      default:     req_n = 3'b000;
    endcase
  end

  // ---------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      pos    <= 2'd1;
      target <= 2'd1;
      Dir    <= 1'b1;
      timer  <= 8'd0;
      Pend   <= 3'b000;
      Req    <= 3'b000;
    end else begin
      state  <= state_n;
      pos    <= pos_n;
      target <= target_n;
      Dir    <= dir_n;
      timer  <= timer_n;
      Pend   <= pend_n;
      Req    <= req_n;
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_elev_dispatch.sv
module tb_elev_dispatch;

  logic       clk;
  logic       Reset;
  logic [3:1] Btn;
  logic       FLR1, FLR2, FLR3;
  logic       Door;
  logic [3:1] Req;
  logic [3:1] Pend;
  logic       Dir;
  logic       Busy;

  int unsigned vectors;
  int unsigned miscompares;

  elev_dispatch #(.IDLE_TO(4)) dut (
    .clk  (clk),
    .Reset(Reset),
    .Btn  (Btn),
    .FLR1 (FLR1),
    .FLR2 (FLR2),
    .FLR3 (FLR3),
    .Door (Door),
    .Req  (Req),
    .Pend (Pend),
    .Dir  (Dir),
    .Busy (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flr(input int f);
    FLR1 = (f == 1);
    FLR2 = (f == 2);
    FLR3 = (f == 3);
  endtask

  task automatic outs(input string tag, input logic [3:1] req,
                      input logic [3:1] pend, input logic busy);
    chk({tag, ".req"},  8'(Req),  8'(req));
    chk({tag, ".pend"}, 8'(Pend), 8'(pend));
    chk({tag, ".busy"}, 8'(Busy), 8'(busy));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset = 1'b0;
    Btn   = 3'b000;
    Door  = 1'b0;
    flr(1);

    // reset state
    #12;
    outs("rst", 3'b000, 3'b000, 1'b0);
    chk("rst.dir", 8'(Dir), 8'd1);
    @(posedge clk); #1;
    Reset = 1'b1;
    step();

    // trip 1 -> 3, with invalid floor readings on the way
    Btn = 3'b100; step(); Btn = 3'b000;
    outs("a.latch", 3'b000, 3'b100, 1'b0);
    step(); outs("a.select", 3'b000, 3'b100, 1'b1);
    step(); outs("a.issue", 3'b100, 3'b100, 1'b1);
    step(); outs("a.wait", 3'b100, 3'b100, 1'b1);
    FLR1 = 1'b0; step(); outs("a.nofloor", 3'b100, 3'b100, 1'b1);
    FLR1 = 1'b1; FLR2 = 1'b1; step(); outs("a.multihot", 3'b100, 3'b100, 1'b1);
    flr(2); step(); outs("a.flr2", 3'b100, 3'b100, 1'b1);
    flr(3); step(); outs("a.flr3", 3'b100, 3'b100, 1'b1);
    Door = 1'b1; step(); outs("a.clear", 3'b000, 3'b100, 1'b1);
    step(); outs("a.cleared", 3'b000, 3'b000, 1'b1);
    Door = 1'b0; step(); outs("a.idle", 3'b000, 3'b000, 1'b0);

    // idle at floor 3 with IDLE_TO=4 -> homing
    repeat (4) step();
    chk("home.before", 8'(Busy), 8'd0);
    step();
    outs("home.enter", 3'b001, 3'b000, 1'b1);
    chk("home.dir", 8'(Dir), 8'd0);
    flr(2); step(); outs("home.flr2", 3'b001, 3'b000, 1'b1);
    flr(1); step(); outs("home.flr1", 3'b001, 3'b000, 1'b1);
    step(); outs("home.done", 3'b000, 3'b000, 1'b0);
    chk("home.dirheld", 8'(Dir), 8'd0);

    // trip 1 -> 3 with pickup at floor 2
    Btn = 3'b100; step(); Btn = 3'b000;
    step(); outs("b.select", 3'b000, 3'b100, 1'b1);
    step(); outs("b.issue", 3'b100, 3'b100, 1'b1);
    chk("b.dirflip", 8'(Dir), 8'd1);
    Btn = 3'b010; step(); Btn = 3'b000;
    outs("b.wait", 3'b100, 3'b110, 1'b1);
    flr(2); step(); outs("b.pickup", 3'b010, 3'b110, 1'b1);
    Door = 1'b1; step(); outs("b.clear2", 3'b000, 3'b110, 1'b1);
    step(); chk("b.pend2off", 8'(Pend), 8'(3'b100));
    Door = 1'b0; step(); outs("b.reselect", 3'b000, 3'b100, 1'b1);
    step(); outs("b.issue3", 3'b100, 3'b100, 1'b1);
    step();
    flr(3); step(); outs("b.flr3", 3'b100, 3'b100, 1'b1);
    Door = 1'b1; step(); step();
    Door = 1'b0; step(); outs("b.idle", 3'b000, 3'b000, 1'b0);

    // car at floor 2 going up, calls on 1 and 3
    Reset = 1'b0; flr(2); #1;
    outs("c.rst", 3'b000, 3'b000, 1'b0);
    step(); Reset = 1'b1;
    step();
    Btn = 3'b101; step(); Btn = 3'b000;
    step();
    step(); outs("c.issue3", 3'b100, 3'b101, 1'b1);
    chk("c.dirup", 8'(Dir), 8'd1);
    step();
    flr(3); step();
    Door = 1'b1; step(); step();
    chk("c.pend1", 8'(Pend), 8'(3'b001));
    Door = 1'b0; step(); outs("c.reselect", 3'b000, 3'b001, 1'b1);
    step(); outs("c.issue1", 3'b001, 3'b001, 1'b1);
    chk("c.dirdown", 8'(Dir), 8'd0);
    step();
    flr(2); step(); outs("c.pass2", 3'b001, 3'b001, 1'b1);
    flr(1); step();
    Door = 1'b1; step(); step();
    Door = 1'b0; step(); outs("c.idle", 3'b000, 3'b000, 1'b0);

    // clear wins against a same-cycle press of the served floor
    Btn = 3'b010; step(); Btn = 3'b000;
    step();
    step(); outs("d.issue2", 3'b010, 3'b010, 1'b1);
    step();
    flr(2); step(); outs("d.flr2", 3'b010, 3'b010, 1'b1);
    Door = 1'b1; step(); outs("d.clear", 3'b000, 3'b010, 1'b1);
    Btn = 3'b010; step(); Btn = 3'b000;
    chk("d.swallow", 8'(Pend), 8'(3'b000));
    Door = 1'b0; step(); outs("d.idle", 3'b000, 3'b000, 1'b0);
    Btn = 3'b010; step(); Btn = 3'b000;
    chk("d.relatch", 8'(Pend), 8'(3'b010));
    step();
    step(); outs("d.reissue", 3'b010, 3'b010, 1'b1);
    step();
    Door = 1'b1; step(); step();
    chk("d.served", 8'(Pend), 8'(3'b000));
    Door = 1'b0; step(); outs("d.idle2", 3'b000, 3'b000, 1'b0);

    // homing from floor 2 aborted by a call
    repeat (4) step();
    step(); outs("e.home", 3'b001, 3'b000, 1'b1);
    Btn = 3'b100; step(); Btn = 3'b000;
    outs("e.abort", 3'b000, 3'b100, 1'b1);
    step(); outs("e.issue3", 3'b100, 3'b100, 1'b1);
    chk("e.dir", 8'(Dir), 8'd1);
    step();
    Btn = 3'b011; step(); Btn = 3'b000;
    outs("e.wait", 3'b100, 3'b111, 1'b1);

    // reset mid-trip acts immediately and ignores buttons
    #2; Reset = 1'b0; #1;
    outs("f.rst", 3'b000, 3'b000, 1'b0);
    chk("f.dir", 8'(Dir), 8'd1);
    Btn = 3'b111; step(); step();
    outs("f.held", 3'b000, 3'b000, 1'b0);
    Btn = 3'b000; flr(1);
    @(posedge clk); #1;
    Reset = 1'b1;
    outs("f.release", 3'b000, 3'b000, 1'b0);
    Btn = 3'b001; step(); Btn = 3'b000;
    outs("f.latch", 3'b000, 3'b001, 1'b0);
    step(); chk("f.busy", 8'(Busy), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
